// File: rtl/slot_io_ctrl.sv
// slot_io_ctrl: per-slot pad I/O controller with input synchroniser, glitch
// filter, sticky edge capture/interrupt and a small register interface.
// Optional output watchdog enabled by defining SLOT_IO_WDT_EN.
module slot_io_ctrl #(
    parameter int unsigned NUM_PINS    = 22,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reg_wr_en,
    input  logic                reg_rd_en,
    input  logic [3:0]          reg_addr,
    input  logic [31:0]         reg_wr_data,
    output logic [31:0]         reg_rd_data,
    output logic                reg_rd_valid,
    input  logic [NUM_PINS-1:0] slot_in,
    output logic [NUM_PINS-1:0] slot_out,
    output logic [NUM_PINS-1:0] slot_outen,
    output logic                irq
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

    localparam logic [3:0] A_OUT       = 4'h0;
    localparam logic [3:0] A_OUTEN     = 4'h1;
    localparam logic [3:0] A_IN        = 4'h2;
    localparam logic [3:0] A_RISE      = 4'h3;
    localparam logic [3:0] A_FALL      = 4'h4;
    localparam logic [3:0] A_MASK      = 4'h5;
    localparam logic [3:0] A_FILTER    = 4'h6;
    localparam logic [3:0] A_WDT_LIMIT = 4'h7;
    localparam logic [3:0] A_WDT_STAT  = 4'h8;

    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [FILTER_W-1:0] cnt_q  [NUM_PINS];
    logic [FILTER_W-1:0] cnt_d  [NUM_PINS];
    logic [NUM_PINS-1:0] out_q, out_d, outen_q, outen_d;
    logic [NUM_PINS-1:0] rise_q, rise_d, fall_q, fall_d, mask_q, mask_d;
    logic [NUM_PINS-1:0] filt_q, filt_d, prev_q, prev_d;
    logic [FILTER_W-1:0] filter_q, filter_d;
    logic [ARM_W-1:0]    arm_q, arm_d;
    logic                irq_q, irq_d, rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d, rd_mux;
    logic [NUM_PINS-1:0] sync_w, wr_pins;
    logic                arming, wdt_trip, wdt_fire;
    logic                unused_wr_hi;

    assign sync_w       = sync_q[SYNC_STAGES-1];
    assign arming       = (arm_q < ARM_W'(ARM_CYCLES));
    assign wr_pins      = reg_wr_data[NUM_PINS-1:0];
    assign unused_wr_hi = ^reg_wr_data[DATA_W-1:NUM_PINS];

`ifdef SLOT_IO_WDT_EN
    logic [DATA_W-1:0] wdt_limit_q, wdt_limit_d, wdt_cnt_q, wdt_cnt_d;
    logic              trip_q, trip_d;

    // Watchdog: counts idle cycles since the last OUT write and drops OUTEN on expiry
    always_comb begin
        wdt_limit_d = wdt_limit_q;
        wdt_cnt_d   = wdt_cnt_q;
        trip_d      = trip_q;
        wdt_fire    = 1'b0;
        if (reg_wr_en && reg_addr == A_WDT_LIMIT) wdt_limit_d = reg_wr_data;
        if ((reg_wr_en && (reg_addr == A_OUT || reg_addr == A_WDT_LIMIT)) || wdt_limit_q == '0) begin
            wdt_cnt_d = '0;
        end else if (wdt_cnt_q != wdt_limit_q) begin
            wdt_cnt_d = wdt_cnt_q + DATA_W'(1);
            wdt_fire  = (wdt_cnt_q + DATA_W'(1) == wdt_limit_q);
        end
        if (reg_wr_en && reg_addr == A_WDT_STAT && reg_wr_data[0]) trip_d = 1'b0;
        if (wdt_fire) trip_d = 1'b1;
    end

    // Watchdog state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_limit_q <= '0;
            wdt_cnt_q   <= '0;
            trip_q      <= 1'b0;
        end else begin
            wdt_limit_q <= wdt_limit_d;
            wdt_cnt_q   <= wdt_cnt_d;
            trip_q      <= trip_d;
        end
    end

    assign wdt_trip = trip_q;
`else
    assign wdt_trip = 1'b0;
    assign wdt_fire = 1'b0;
`endif

    // Input synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= slot_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Glitch filter and arming; during arming filtered loads sync directly
    always_comb begin
        filt_d = filt_q;
        arm_d  = arming ? arm_q + ARM_W'(1) : arm_q;
        for (int i = 0; i < NUM_PINS; i++) begin
            cnt_d[i] = '0;
            if (arming) begin
                filt_d[i] = sync_w[i];
            end else if (sync_w[i] != filt_q[i]) begin
                if (cnt_q[i] >= filter_q)   filt_d[i] = sync_w[i];
                else if (cnt_q[i] != '1)    cnt_d[i]  = cnt_q[i] + FILTER_W'(1);
                else                        cnt_d[i]  = cnt_q[i];
            end
        end
        // keep prev aligned with filtered while arming so no edge is seen on release
        prev_d = arming ? filt_d : filt_q;
    end

    // Register writes, sticky edge capture, interrupt and read data
    always_comb begin
        out_d      = out_q;
        outen_d    = outen_q;
        mask_d     = mask_q;
        filter_d   = filter_q;
        rise_d     = rise_q;
        fall_d     = fall_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = reg_rd_en;
        rd_mux     = '0;
        if (reg_wr_en) begin
            case (reg_addr)
                A_OUT:    out_d    = wr_pins;
                A_OUTEN:  if (!wdt_trip) outen_d = wr_pins;
                A_RISE:   rise_d   = rise_q & ~wr_pins;
                A_FALL:   fall_d   = fall_q & ~wr_pins;
                A_MASK:   mask_d   = wr_pins;
                A_FILTER: filter_d = reg_wr_data[FILTER_W-1:0];
                default:  ;
            endcase
        end
        if (wdt_fire) outen_d = '0;
        // a new edge wins over a simultaneous w1c
        if (!arming) begin
            rise_d = rise_d | (filt_q & ~prev_q);
            fall_d = fall_d | (~filt_q & prev_q);
        end
        irq_d = (|((rise_q | fall_q) & mask_q)) | wdt_trip;
        case (reg_addr)
            A_OUT:       rd_mux = DATA_W'(out_q);
            A_OUTEN:     rd_mux = DATA_W'(outen_q);
            A_IN:        rd_mux = DATA_W'(filt_q);
            A_RISE:      rd_mux = DATA_W'(rise_q);
            A_FALL:      rd_mux = DATA_W'(fall_q);
            A_MASK:      rd_mux = DATA_W'(mask_q);
            A_FILTER:    rd_mux = DATA_W'(filter_q);
`ifdef SLOT_IO_WDT_EN
            A_WDT_LIMIT: rd_mux = wdt_limit_q;
            A_WDT_STAT:  rd_mux = DATA_W'(trip_q);
`endif
            default:     rd_mux = '0;
        endcase
        if (reg_rd_en) rd_data_d = rd_mux;
    end

    // Main state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            outen_q    <= '0;
            mask_q     <= '0;
            filter_q   <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            arm_q      <= '0;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
        end else begin
            out_q      <= out_d;
            outen_q    <= outen_d;
            mask_q     <= mask_d;
            filter_q   <= filter_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            arm_q      <= arm_d;
            irq_q      <= irq_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign slot_out     = out_q;
    assign slot_outen   = outen_q;
    assign irq          = irq_q;
    assign reg_rd_data  = rd_data_q;
    assign reg_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_slot_io_ctrl.sv
// Directed self-checking bench for slot_io_ctrl (watchdog checks only when
// SLOT_IO_WDT_EN is defined).
module tb_slot_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr_en, reg_rd_en;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wr_data, reg_rd_data;
    logic        reg_rd_valid;
    logic [21:0] slot_in, slot_out, slot_outen;
    logic        irq;
    logic [31:0] d;
    int          checks = 0;
    int          errors = 0;

    slot_io_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .reg_wr_en    (reg_wr_en),
        .reg_rd_en    (reg_rd_en),
        .reg_addr     (reg_addr),
        .reg_wr_data  (reg_wr_data),
        .reg_rd_data  (reg_rd_data),
        .reg_rd_valid (reg_rd_valid),
        .slot_in      (slot_in),
        .slot_out     (slot_out),
        .slot_outen   (slot_outen),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // called just after a negedge; write lands on the next posedge
    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        reg_wr_en = 1'b1; reg_addr = a; reg_wr_data = v;
        @(negedge clk);
        reg_wr_en = 1'b0;
    endtask

    // called just after a negedge; samples the value held before the next posedge
    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        reg_rd_en = 1'b1; reg_addr = a;
        @(negedge clk);
        reg_rd_en = 1'b0;
        check("rd_valid", 32'(reg_rd_valid), 32'd1);
        v = reg_rd_data;
    endtask

    initial begin
        rst = 1'b1; reg_wr_en = 1'b0; reg_rd_en = 1'b0; reg_addr = '0;
        reg_wr_data = '0; slot_in = '0;
        repeat (2) @(negedge clk);
        check("rst_slot_out",   32'(slot_out),     32'h0);
        check("rst_slot_outen", 32'(slot_outen),   32'h0);
        check("rst_irq",        32'(irq),          32'h0);
        check("rst_rd_valid",   32'(reg_rd_valid), 32'h0);
        check("rst_rd_data",    reg_rd_data,       32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // register access
        wr(4'h0, 32'hFFFF_FFFF);
        check("out_mask_pins", 32'(slot_out), 32'h003F_FFFF);
        wr(4'h0, 32'h0015_5555);
        wr(4'h1, 32'h003F_FFFF);
        check("slot_out",   32'(slot_out),   32'h0015_5555);
        check("slot_outen", 32'(slot_outen), 32'h003F_FFFF);
        rd(4'h0, d); check("rd_out",   d, 32'h0015_5555);
        rd(4'h1, d); check("rd_outen", d, 32'h003F_FFFF);
        rd(4'hF, d); check("rd_unmapped", d, 32'h0);
        @(negedge clk);
        check("rd_valid_drop", 32'(reg_rd_valid), 32'h0);
`ifndef SLOT_IO_WDT_EN
        wr(4'h7, 32'h0000_1234);
        rd(4'h7, d); check("rd_wdt_absent", d, 32'h0);
`endif

        // filter accept: edge then IN updates after 2+4+1 edges, RISE one later
        wr(4'h6, 32'd4);
        slot_in[3] = 1'b1;
        repeat (6) rd(4'h2, d);
        rd(4'h2, d); check("in_before_accept", d, 32'h0);
        rd(4'h2, d); check("in_accept",        d, 32'h8);
        rd(4'h3, d); check("rise_accept",      d, 32'h8);

        // filter reject: 3-cycle pulse on pin 5
        wr(4'h3, 32'h8);
        slot_in[5] = 1'b1;
        repeat (3) @(negedge clk);
        slot_in[5] = 1'b0;
        repeat (10) @(negedge clk);
        rd(4'h2, d); check("in_reject",   d, 32'h8);
        rd(4'h3, d); check("rise_reject", d, 32'h0);
        check("irq_reject", 32'(irq), 32'h0);

        // interrupt and w1c
        wr(4'h5, 32'h8);
        slot_in[3] = 1'b0;
        repeat (12) @(negedge clk);
        rd(4'h4, d); check("fall_set", d, 32'h8);
        check("irq_fall", 32'(irq), 32'h1);
        wr(4'h4, 32'h8);
        check("irq_w1c_edge", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'h0);

        // new falling edge captured on the same edge as the w1c (FILTER=0)
        slot_in[3] = 1'b1;
        repeat (12) @(negedge clk);
        wr(4'h6, 32'd0);
        slot_in[3] = 1'b0;
        repeat (3) @(negedge clk);
        wr(4'h4, 32'h8);
        rd(4'h4, d); check("fall_set_wins", d, 32'h8);

        // async reset and arming with pins held high
        slot_in = 22'h3F_FFFF;
        rst = 1'b1;
        #1;
        check("outen_async_rst", 32'(slot_outen), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rd(4'h2, d); check("arm_in",   d, 32'h003F_FFFF);
        rd(4'h3, d); check("arm_rise", d, 32'h0);
        rd(4'h4, d); check("arm_fall", d, 32'h0);
        check("arm_irq", 32'(irq), 32'h0);

`ifdef SLOT_IO_WDT_EN
        // watchdog expiry 100 cycles after the limit write
        wr(4'h1, 32'hFF);
        wr(4'h7, 32'd100);
        repeat (99) @(negedge clk);
        check("wdt_before", 32'(slot_outen), 32'hFF);
        @(negedge clk);
        check("wdt_outen_off", 32'(slot_outen), 32'h0);
        rd(4'h8, d); check("wdt_trip", d, 32'h1);
        check("wdt_irq", 32'(irq), 32'h1);
        wr(4'h1, 32'hFF);
        check("wdt_outen_locked", 32'(slot_outen), 32'h0);
        wr(4'h8, 32'h1);
        wr(4'h1, 32'h0F);
        check("wdt_outen_unlocked", 32'(slot_outen), 32'h0F);
        wr(4'h7, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
